lcm_calc: RTL and testbench

LCM_CALC -- requirements
Module: lcm_calc

---
 rtl/lcm_pkg.sv | 23 ++
 rtl/lcm_calc_div_restore.sv | 71 +++++++
 rtl/lcm_calc.sv | 130 +++++++++++++
 tb/tb_lcm_calc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM calculator.
//   state_t   : controller state encoding (IDLE, DIV, MUL)
//   OP_W      : operand width (A, B, gcd, quotient, remainder)
//   RES_W     : result / accumulator width
//   STEPS     : iterations per datapath phase (one per operand bit)
//   CNT_W     : width of the step counters
//   LAST_STEP : step counter value of the final iteration in a phase
package lcm_pkg;

   localparam int OP_W  = 12;
   localparam int RES_W = 24;
   localparam int STEPS = 12;
   localparam int CNT_W = 4;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      MUL  = 2'd2
   } state_t;

endpackage

// File: rtl/lcm_calc_div_restore.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk, clr_n : clock, asynchronous active-low clear
//   start      : latch dividend/divisor and begin (must not be issued
//                with divisor = 0)
//   dividend   : OP_W-bit numerator
//   divisor    : OP_W-bit denominator
//   done       : high during the cycle whose rising edge performs the
//                final step; quotient/remainder are final after that edge
//   quotient   : OP_W-bit quotient (holds until the next start)
//   remainder  : OP_W-bit remainder (holds until the next start)
module div_restore
   import lcm_pkg::*;
(
   input  logic            clk,
   input  logic            clr_n,
   input  logic            start,
   input  logic [OP_W-1:0] dividend,
   input  logic [OP_W-1:0] divisor,
   output logic            done,
   output logic [OP_W-1:0] quotient,
   output logic [OP_W-1:0] remainder
);

   logic             run_reg;
   logic [CNT_W-1:0] cnt_reg;
   // Dividend bits shift out of the top while quotient bits shift in.
   logic [OP_W-1:0]  dq_reg;
   logic [OP_W-1:0]  rem_reg;
   logic [OP_W-1:0]  dvs_reg;

   logic [OP_W:0]    rem_shift;
   logic [OP_W-1:0]  rem_diff;
   logic             fits;

   // Partial remainder is always below the divisor, so once the trial
   // subtraction succeeds the result fits in OP_W bits and modulo
   // arithmetic on the low bits is exact.
   always_comb begin
      rem_shift = {rem_reg, dq_reg[OP_W-1]};
      fits      = (rem_shift >= {1'b0, dvs_reg});
      rem_diff  = rem_shift[OP_W-1:0] - dvs_reg;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         run_reg <= 1'b0;
         cnt_reg <= '0;
         dq_reg  <= '0;
         rem_reg <= '0;
         dvs_reg <= '0;
      end else if (start) begin
         run_reg <= 1'b1;
         cnt_reg <= '0;
         dq_reg  <= dividend;
         rem_reg <= '0;
         dvs_reg <= divisor;
      end else if (run_reg) begin
         dq_reg  <= {dq_reg[OP_W-2:0], fits};
         rem_reg <= fits ? rem_diff : rem_shift[OP_W-1:0];
         cnt_reg <= cnt_reg + 1'b1;
         if (cnt_reg == LAST_STEP) begin
            run_reg <= 1'b0;
         end
      end
   end

   assign done      = run_reg && (cnt_reg == LAST_STEP);
   assign quotient  = dq_reg;
   assign remainder = rem_reg;

endmodule

// File: rtl/lcm_calc.sv
// LCM calculator: lcm = (A / gcd) * B using a restoring divider followed
// by an inline shift-add multiplier. gcd comes from an upstream engine;
// a nonzero remainder of A/gcd flags the inputs as inconsistent via err.
//   clk, clr_n : clock, asynchronous active-low clear
//   start      : request, accepted only while busy = 0
//   A, B, gcd  : 12-bit unsigned operands, sampled on the accepting edge
//   busy       : high while a computation is in progress
//   lcm        : 24-bit result, holds until the next result is written
//   lcm_valid  : one-cycle pulse marking a new lcm value
//   err        : error qualifier, meaningful only with lcm_valid
module lcm_calc
   import lcm_pkg::*;
(
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [OP_W-1:0]  A,
   input  logic [OP_W-1:0]  B,
   input  logic [OP_W-1:0]  gcd,
   output logic             busy,
   output logic [RES_W-1:0] lcm,
   output logic             lcm_valid,
   output logic             err
);

   state_t           state_reg, state_next;
   logic             div_start;
   logic             mul_last;
   logic             div_done;
   logic [OP_W-1:0]  quotient;
   logic [OP_W-1:0]  remainder;

   logic [CNT_W-1:0] mul_cnt_reg;
   logic [RES_W-1:0] mcand_reg;
   logic [RES_W-1:0] acc_reg;
   logic [RES_W-1:0] acc_next;

   div_restore u_div (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (div_start),
      .dividend  (A),
      .divisor   (gcd),
      .done      (div_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      div_start  = 1'b0;
      mul_last   = 1'b0;
      case (state_reg)
         IDLE: begin
            // Zero operands and gcd = 0 are resolved in IDLE in one cycle.
            if (start && (A != '0) && (B != '0) && (gcd != '0)) begin
               div_start  = 1'b1;
               state_next = DIV;
            end
         end
         DIV: begin
            if (div_done) begin
               state_next = MUL;
            end
         end
         MUL: begin
            if (mul_cnt_reg == LAST_STEP) begin
               mul_last   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Multiplicand is pre-shifted each step, so the quotient bit selected
   // by the step counter decides whether it is added.
   assign acc_next = acc_reg + (quotient[mul_cnt_reg] ? mcand_reg : '0);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         mul_cnt_reg <= '0;
         mcand_reg   <= '0;
         acc_reg     <= '0;
         lcm         <= '0;
         lcm_valid   <= 1'b0;
         err         <= 1'b0;
      end else begin
         lcm_valid <= 1'b0;
         err       <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (div_start) begin
                  mul_cnt_reg <= '0;
                  mcand_reg   <= {{(RES_W-OP_W){1'b0}}, B};
                  acc_reg     <= '0;
               end else if (start) begin
                  // Immediate result: err only when operands are nonzero,
                  // which here implies gcd = 0.
                  lcm       <= '0;
                  err       <= (A != '0) && (B != '0);
                  lcm_valid <= 1'b1;
               end
            end
            MUL: begin
               acc_reg     <= acc_next;
               mcand_reg   <= {mcand_reg[RES_W-2:0], 1'b0};
               mul_cnt_reg <= mul_cnt_reg + 1'b1;
               if (mul_last) begin
                  lcm       <= acc_next;
                  err       <= (remainder != '0);
                  lcm_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_lcm_calc.sv
module tb_lcm_calc;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        start;
   logic [11:0] A, B, gcd;
   logic        busy;
   logic [23:0] lcm;
   logic        lcm_valid;
   logic        err;

   int total_checks = 0;
   int passed_checks = 0;

   typedef struct {
      int a;
      int b;
      int g;
      int exp_lcm;
      int exp_err;
      int exp_edge;
   } vec_t;

   vec_t vecs[12];

   lcm_calc dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .A         (A),
      .B         (B),
      .gcd       (gcd),
      .busy      (busy),
      .lcm       (lcm),
      .lcm_valid (lcm_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      else
         passed_checks++;
   endtask

   function automatic int gcd_f(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Reference: result from plain arithmetic; edge index (relative to the
   // accepting edge) at which lcm_valid is written.
   function automatic vec_t model(input int a, input int b, input int g);
      vec_t v;
      v.a = a; v.b = b; v.g = g;
      if (a == 0 || b == 0) begin
         v.exp_lcm = 0; v.exp_err = 0; v.exp_edge = 0;
      end else if (g == 0) begin
         v.exp_lcm = 0; v.exp_err = 1; v.exp_edge = 0;
      end else begin
         v.exp_lcm  = (a / g) * b;
         v.exp_err  = (a % g != 0) ? 1 : 0;
         v.exp_edge = 24;
      end
      return v;
   endfunction

   // Called at a negedge: present a request and let the accepting edge pass.
   task automatic launch(input int a, input int b, input int g);
      A = 12'(a); B = 12'(b); gcd = 12'(g); start = 1'b1;
      @(posedge clk);
   endtask

   // Called right after the accepting edge. Inputs are scrambled after E0
   // to confirm they no longer matter.
   task automatic wait_valid(output int edge_k, output logic [23:0] l,
                             output logic e, output int busy_n);
      edge_k = -1; l = '0; e = 1'b0; busy_n = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            A = 12'($urandom); B = 12'($urandom); gcd = 12'($urandom);
         end
         if (busy) busy_n++;
         if (lcm_valid) begin
            edge_k = n - 1;
            l = lcm;
            e = err;
            break;
         end
      end
   endtask

   // One cycle after the pulse: pulse gone, err cleared, result held.
   task automatic check_after(input int exp_lcm);
      @(negedge clk);
      check("valid_one_cycle", 32'(lcm_valid), 0);
      check("err_clears", 32'(err), 0);
      check("lcm_holds", 32'(lcm), 32'(exp_lcm));
   endtask

   task automatic run_vec(input vec_t v);
      int k, bn;
      logic [23:0] l;
      logic e;
      launch(v.a, v.b, v.g);
      wait_valid(k, l, e, bn);
      $display("req A=%0d B=%0d gcd=%0d -> lcm=%0d err=%0d edge=%0d busy_cycles=%0d",
               v.a, v.b, v.g, l, e, k, bn);
      check("valid_edge", 32'(k), 32'(v.exp_edge));
      check("lcm", 32'(l), 32'(v.exp_lcm));
      check("err", 32'(e), 32'(v.exp_err));
      check("busy_cycles", 32'(bn), 32'(v.exp_edge));
      check_after(v.exp_lcm);
   endtask

   initial begin
      int k, bn, vcount;
      logic [23:0] l;
      logic e;
      vec_t v;

      vecs[0]  = '{12, 18, 6, 36, 0, 24};
      vecs[1]  = '{4095, 4094, 1, 16764930, 0, 24};
      vecs[2]  = '{0, 7, 7, 0, 0, 0};
      vecs[3]  = '{9, 6, 0, 0, 1, 0};
      vecs[4]  = '{10, 4, 4, 8, 1, 24};
      vecs[5]  = '{7, 0, 3, 0, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 0};
      vecs[7]  = '{1, 1, 1, 1, 0, 24};
      vecs[8]  = '{4095, 4095, 4095, 4095, 0, 24};
      vecs[9]  = '{4095, 4095, 1, 16769025, 0, 24};
      vecs[10] = '{1, 4095, 4095, 0, 1, 24};
      vecs[11] = '{100, 3, 7, 42, 1, 24};

      clr_n = 1'b0; start = 1'b0; A = '0; B = '0; gcd = '0;
      #2;
      check("rst_busy", 32'(busy), 0);
      check("rst_lcm", 32'(lcm), 0);
      check("rst_valid", 32'(lcm_valid), 0);
      check("rst_err", 32'(err), 0);
      repeat (2) @(negedge clk);

      // First request on the first edge after reset release.
      clr_n = 1'b1;
      run_vec(model(12, 18, 6));

      // Directed table.
      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Randomized requests against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         int a, b, g, mode;
         a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4095));
         b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4095));
         mode = $urandom_range(0, 3);
         if (mode <= 1)      g = gcd_f(a, b);
         else if (mode == 2) g = 0;
         else                g = $urandom_range(1, 4095);
         run_vec(model(a, b, g));
      end

      // Start while busy is ignored; start during the valid cycle is accepted.
      launch(12, 18, 6);
      k = -1; l = '0; e = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (n == 5) begin
            A = 12'd100; B = 12'd3; gcd = 12'd1; start = 1'b1;
         end
         if (n == 6) start = 1'b0;
         if (lcm_valid) begin
            k = n - 1; l = lcm; e = err;
            A = 12'd8; B = 12'd12; gcd = 12'd4; start = 1'b1;
            break;
         end
      end
      $display("req A=12 B=18 gcd=6 with start at E5 -> lcm=%0d err=%0d edge=%0d", l, e, k);
      check("ignored_edge", 32'(k), 24);
      check("ignored_lcm", 32'(l), 36);
      check("ignored_err", 32'(e), 0);
      @(posedge clk);
      wait_valid(k, l, e, bn);
      $display("req A=8 B=12 gcd=4 (during valid) -> lcm=%0d err=%0d edge=%0d", l, e, k);
      check("bb_edge", 32'(k), 24);
      check("bb_lcm", 32'(l), 24);
      check("bb_err", 32'(e), 0);
      check_after(24);
      vcount = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (lcm_valid) vcount++;
      end
      check("no_queued_result", 32'(vcount), 0);

      // Asynchronous clear at E10 aborts the run.
      launch(12, 18, 6);
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2 clr_n = 1'b0;
      #1;
      $display("clear at E10 -> busy=%0d lcm=%0d valid=%0d err=%0d", busy, lcm, lcm_valid, err);
      check("clr_busy", 32'(busy), 0);
      check("clr_lcm", 32'(lcm), 0);
      check("clr_valid", 32'(lcm_valid), 0);
      check("clr_err", 32'(err), 0);
      @(negedge clk);
      @(negedge clk);
      clr_n = 1'b1;
      vcount = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (lcm_valid) vcount++;
      end
      check("aborted_no_valid", 32'(vcount), 0);
      v = model(35, 21, 7);
      run_vec(v);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
